// File: rtl/tetris_pkg.sv
// Shared types and helpers for the falling-piece sequencer slice.
package tetris_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;

    typedef enum logic [2:0] {
        LINE   = 3'd0,
        SQUARE = 3'd1,
        L      = 3'd2,
        REV_L  = 3'd3,
        S      = 3'd4,
        Z      = 3'd5,
        T      = 3'd6
    } piece_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_SPAWN_CHK,
        ST_FALL,
        ST_CHECK,
        ST_STEP,
        ST_LOCK,
        ST_CLEAR,
        ST_GAMEOVER
    } state_t;

    // x^3+x^2+1 Fibonacci step; seven-state cycle, never reaches zero.
    function automatic logic [2:0] lfsr_next(input logic [2:0] s);
        return {s[1:0], s[2] ^ s[1]};
    endfunction

    // At most four rows can clear at once; anything larger is a datapath glitch.
    function automatic logic [2:0] clamp_lines(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction

endpackage

// File: rtl/tetris_seq_ctrl_if.sv
// Bundle of sequencer control, handshake and status signals.
interface tetris_seq_ctrl_if;
    logic        start;
    logic        tick;
    logic        soft_drop;
    logic        spawn;
    logic [2:0]  piece_type;
    logic        chk_req;
    logic        chk_ack;
    logic        chk_hit;
    logic        step_en;
    logic        lock;
    logic        clr_req;
    logic        clr_done;
    logic [2:0]  clr_lines;
    logic [15:0] lines_total;
    logic [3:0]  level;
    logic        game_over;
    logic        busy;

    modport master (
        input  start, tick, soft_drop, chk_ack, chk_hit, clr_done, clr_lines,
        output spawn, piece_type, chk_req, step_en, lock, clr_req,
               lines_total, level, game_over, busy
    );

    modport slave (
        output start, tick, soft_drop, chk_ack, chk_hit, clr_done, clr_lines,
        input  spawn, piece_type, chk_req, step_en, lock, clr_req,
               lines_total, level, game_over, busy
    );
endinterface

// File: rtl/tetris_gravity_timer.sv
// Frame-tick gravity pacing; fire marks the tick that completes one period.
module tetris_gravity_timer #(
    parameter int GRAV_INIT   = 48,
    parameter int GRAV_STEP   = 3,
    parameter int GRAV_MIN    = 2,
    parameter int SOFT_PERIOD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       tick,
    input  logic       soft_drop,
    input  logic [3:0] level,
    output logic       fire
);

    logic [7:0]        grav_cnt;
    logic [7:0]        period;
    logic signed [8:0] p_lvl;

    // Signed so a steep level slope goes negative and is caught by the floor.
    always_comb begin
        p_lvl = $signed(9'(GRAV_INIT) - 9'(level) * 9'(GRAV_STEP));
        if (soft_drop)
            period = 8'(SOFT_PERIOD);
        else if (p_lvl < $signed(9'(GRAV_MIN)))
            period = 8'(GRAV_MIN);
        else
            period = 8'(p_lvl);
    end

    // >= rather than == so a count left above a shortened period still fires.
    assign fire = en && tick && (({1'b0, grav_cnt} + 9'd1) >= {1'b0, period});

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            grav_cnt <= '0;
        else if (clr)
            grav_cnt <= '0;
        else if (en && tick)
            grav_cnt <= fire ? 8'd0 : grav_cnt + 8'd1;
    end

endmodule

// File: rtl/tetris_seq_ctrl.sv
// Game-level sequencer: spawn, gravity, collision/clear handshakes, scoring.
module tetris_seq_ctrl
    import tetris_pkg::*;
#(
    parameter int GRAV_INIT       = 48,
    parameter int GRAV_STEP       = 3,
    parameter int GRAV_MIN        = 2,
    parameter int SOFT_PERIOD     = 2,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 15
) (
    input  logic              clk,
    input  logic              rst,
    tetris_seq_ctrl_if.master bus
);

    state_t      state, state_nx;
    logic [2:0]  lfsr;
    logic [2:0]  piece_type_q;
    logic [15:0] lines_total_q;
    logic [3:0]  level_q;
    logic [3:0]  lines_in_lvl;
    logic        fire;
    logic        game_start;
    logic [2:0]  cl;
    logic [16:0] lt_sum;
    logic [4:0]  lvl_sum;

    assign game_start = ((state == ST_IDLE) || (state == ST_GAMEOVER)) && bus.start;

    tetris_gravity_timer #(
        .GRAV_INIT  (GRAV_INIT),
        .GRAV_STEP  (GRAV_STEP),
        .GRAV_MIN   (GRAV_MIN),
        .SOFT_PERIOD(SOFT_PERIOD)
    ) u_grav (
        .clk      (clk),
        .rst      (rst),
        .en       (state == ST_FALL),
        .clr      (game_start),
        .tick     (bus.tick),
        .soft_drop(bus.soft_drop),
        .level    (level_q),
        .fire     (fire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Outputs are pure state decodes so reset drops every request immediately.
    always_comb begin
        state_nx      = state;
        bus.spawn     = 1'b0;
        bus.chk_req   = 1'b0;
        bus.step_en   = 1'b0;
        bus.lock      = 1'b0;
        bus.clr_req   = 1'b0;
        bus.game_over = 1'b0;
        case (state)
            ST_IDLE:      if (bus.start) state_nx = ST_SPAWN;
            ST_SPAWN: begin
                bus.spawn = 1'b1;
                state_nx  = ST_SPAWN_CHK;
            end
            ST_SPAWN_CHK: begin
                bus.chk_req = 1'b1;
                if (bus.chk_ack) state_nx = bus.chk_hit ? ST_GAMEOVER : ST_FALL;
            end
            ST_FALL:      if (fire) state_nx = ST_CHECK;
            ST_CHECK: begin
                bus.chk_req = 1'b1;
                if (bus.chk_ack) state_nx = bus.chk_hit ? ST_LOCK : ST_STEP;
            end
            ST_STEP: begin
                bus.step_en = 1'b1;
                state_nx    = ST_FALL;
            end
            ST_LOCK: begin
                bus.lock = 1'b1;
                state_nx = ST_CLEAR;
            end
            ST_CLEAR: begin
                bus.clr_req = 1'b1;
                if (bus.clr_done) state_nx = ST_SPAWN;
            end
            ST_GAMEOVER: begin
                bus.game_over = 1'b1;
                if (bus.start) state_nx = ST_SPAWN;
            end
            default:      state_nx = ST_IDLE;
        endcase
        bus.busy = (state != ST_IDLE) && (state != ST_GAMEOVER);
    end

    always_comb begin
        cl      = clamp_lines(bus.clr_lines);
        lt_sum  = {1'b0, lines_total_q} + 17'(cl);
        lvl_sum = {1'b0, lines_in_lvl} + {2'b00, cl};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr          <= 3'b001;
            piece_type_q  <= '0;
            lines_total_q <= '0;
            level_q       <= '0;
            lines_in_lvl  <= '0;
        end else begin
            if (game_start) begin
                lines_total_q <= '0;
                level_q       <= '0;
                lines_in_lvl  <= '0;
            end
            // SPAWN is never held, so this is exactly one update per entry.
            if (state_nx == ST_SPAWN) begin
                piece_type_q <= lfsr - 3'd1;
                lfsr         <= lfsr_next(lfsr);
            end
            if ((state == ST_CLEAR) && bus.clr_done) begin
                lines_total_q <= lt_sum[16] ? 16'hFFFF : lt_sum[15:0];
                if (lvl_sum >= 5'(LINES_PER_LEVEL)) begin
                    lines_in_lvl <= 4'(lvl_sum - 5'(LINES_PER_LEVEL));
                    if (level_q < 4'(MAX_LEVEL)) level_q <= level_q + 4'd1;
                end else begin
                    lines_in_lvl <= 4'(lvl_sum);
                end
            end
        end
    end

    assign bus.piece_type  = piece_type_q;
    assign bus.lines_total = lines_total_q;
    assign bus.level       = level_q;

endmodule

// File: doc/tetris_seq_ctrl.md
Name: tetris_seq_ctrl

Overview:
- Game-level sequencer for the falling-piece datapath; decides when each stage of a piece's life happens.
- Spawns pieces with types from an LFSR and paces gravity from frame ticks.
- Runs collision-check and line-clear handshakes, issues one-cycle step/lock strobes, and tracks lines, level and game-over.
- Sits between the frame-tick generator / input debouncer and the move-down, collision and line-clear units.

Parameters:
- GRAV_INIT, 48: frames per gravity step at level 0
- GRAV_STEP, 3: frames removed per level
- GRAV_MIN, 2: floor on gravity period (frames)
- SOFT_PERIOD, 2: frames per step while soft_drop held
- LINES_PER_LEVEL, 10: cleared lines per level increment
- MAX_LEVEL, 15: level saturation value

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  begin game; sampled in IDLE and GAMEOVER
- tick  in  1  one-cycle frame strobe
- soft_drop  in  1  level; selects SOFT_PERIOD
- spawn  out  1  one-cycle pulse; new piece at top
- piece_type  out  3  0..6 (line, square, L, rev-L, S, Z, T); valid from spawn until next spawn
- chk_req  out  1  collision check request; held until chk_ack
- chk_ack  in  1  check complete
- chk_hit  in  1  collision result; valid with chk_ack
- step_en  out  1  one-cycle pulse; move piece down one row
- lock  out  1  one-cycle pulse; merge piece into board
- clr_req  out  1  line-clear request; held until clr_done
- clr_done  in  1  clear complete
- clr_lines  in  3  rows cleared (0..4); valid with clr_done
- lines_total  out  16  lines cleared this game, saturating at 16'hFFFF
- level  out  4  current level
- game_over  out  1  high while in GAMEOVER
- busy  out  1  high in every state except IDLE and GAMEOVER

Behaviour:
- Reset values: all outputs 0; lfsr=3'b001; grav_cnt=0; lines_in_lvl=0; state IDLE.
- LFSR: x^3+x^2+1, next={lfsr[1:0], lfsr[2]^lfsr[1]}. Sequence from seed: 1,2,5,3,7,6,4.
- On entry to SPAWN: piece_type <= lfsr-1, then lfsr advances. Piece order after reset: 0,1,4,2,6,5,3, repeating.
- States and transitions:
  - IDLE: start -> SPAWN; clears lines_total, level, lines_in_lvl, grav_cnt.
  - SPAWN: spawn=1 for one cycle -> SPAWN_CHK.
  - SPAWN_CHK: chk_req=1. On chk_ack: chk_hit -> GAMEOVER, else -> FALL.
  - FALL: on tick, grav_cnt++. When grav_cnt+1 >= period: grav_cnt <= 0 and go to CHECK.
  - CHECK: chk_req=1. On chk_ack: chk_hit -> LOCK, else -> STEP.
  - STEP: step_en=1 for one cycle -> FALL.
  - LOCK: lock=1 for one cycle -> CLEAR.
  - CLEAR: clr_req=1. On clr_done: update counters, then -> SPAWN.
  - GAMEOVER: game_over=1; start -> IDLE-equivalent clear, then SPAWN next cycle (no pass through IDLE).
- Gravity period:
  - soft_drop=1: period = SOFT_PERIOD.
  - otherwise: p = GRAV_INIT - level*GRAV_STEP, computed signed 9-bit; period = max(p, GRAV_MIN).
  - Period is evaluated every FALL cycle. If soft_drop is released with grav_cnt >= the new period, the next tick fires the step.
- tick outside FALL is ignored; grav_cnt holds its value.
- chk_ack/clr_done outside the matching request state are ignored.
- Handshake latency: an ack in cycle N gives a state change at edge N+1. chk_req and clr_req drop in the same edge.
- Counters on clr_done:
  - lines_total += clr_lines, saturating.
  - sum = lines_in_lvl + clr_lines.
  - If sum >= LINES_PER_LEVEL: lines_in_lvl = sum - LINES_PER_LEVEL and level = min(level+1, MAX_LEVEL). At MAX_LEVEL, lines_in_lvl still wraps.
  - Otherwise: lines_in_lvl = sum.
  - clr_lines > 4 is treated as 4.
- Asynchronous reset at any point returns to IDLE and drops all requests the same cycle. An in-flight ack is discarded.

Decomposition:
- Shared package tetris_pkg:
  - piece_t enum (LINE=0, SQUARE, L, REV_L, S, Z, T)
  - state enum
  - BOARD_ROWS=20, BOARD_COLS=10
- One sub-module, tetris_gravity_timer: owns grav_cnt, the period calculation and the fire output; enabled only in FALL.

Test Plan:
- Reset, start, chk_hit=0 always, 48 ticks -> spawn with piece_type=0, then exactly one step_en, on the cycle after the CHECK ack following the 48th tick.
- soft_drop=1 -> step_en every 2 ticks; release at grav_cnt=1 -> next step after 47 more ticks.
- CHECK returns chk_hit=1 -> lock pulse, then clr_req. clr_done with clr_lines=4, three times -> lines_total=12, level=1, period=45.
- Seven consecutive locks with clr_lines=0 -> piece_type sequence 0,1,4,2,6,5,3, then 0 again.
- SPAWN_CHK chk_hit=1 -> game_over=1, busy=0, ticks produce no step_en. start -> spawn with lines_total=0, level=0.
- Assert rst mid-CLEAR with clr_req=1 -> clr_req=0 asynchronously; later clr_done is ignored; state IDLE.
